// File: rtl/ft601_pkg.sv
// Shared definitions for the FT601 FIFO responder: bus width default,
// protocol-error bit indices, the control-strobe bundle and the error-flag helper.
package ft601_pkg;

    localparam int FT601_DATA_WIDTH    = 32;
    localparam int PERR_W              = 4;
    localparam int PERR_WR_FULL        = 0;
    localparam int PERR_RD_EMPTY       = 1;
    localparam int PERR_RD_NO_OE       = 2;
    localparam int PERR_BUS_CONTENTION = 3;

    typedef struct packed {
        logic wren_l;
        logic rden_l;
        logic outen_l;
        logic rst_l;
    } ft601_strobe_t;

    // Protocol violations seen this cycle; a bus-reset cycle ignores all strobes.
    function automatic logic [PERR_W-1:0] proto_flags(
        input ft601_strobe_t strb,
        input logic          tx_full,
        input logic          rx_empty
    );
        logic [PERR_W-1:0] flags;
        flags = {PERR_W{1'b0}};
        if (strb.rst_l) begin
            flags[PERR_WR_FULL]        = !strb.wren_l && tx_full;
            flags[PERR_RD_EMPTY]       = !strb.rden_l && !strb.outen_l && rx_empty;
            flags[PERR_RD_NO_OE]       = !strb.rden_l && strb.outen_l;
            flags[PERR_BUS_CONTENTION] = !strb.wren_l && !strb.outen_l;
        end else begin
            flags = {PERR_W{1'b0}};
        end
        return flags;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count; pushes while full and pops while empty
// are ignored, and flush clears pointers and count without touching storage.
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int                ADDR_W   = $clog2(DEPTH);
    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ZERO_CNT = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W - 1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [ADDR_W:0]       count_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == ZERO_CNT);
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage write; stale words left by a flush are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {ADDR_W{1'b0}};
            rd_ptr_r <= {ADDR_W{1'b0}};
            count_r  <= ZERO_CNT;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{ADDR_W{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ft601_fifo_responder.sv
// FT601-style FIFO-bus responder: controller writes land in W-FIFO for the host,
// host words queue in R-FIFO for controller reads. Protocol checking is built
// only when FT601_RESP_PROTO_CHECK_EN is defined.
module ft601_fifo_responder
    import ft601_pkg::*;
#(
    parameter int DATA_WIDTH = FT601_DATA_WIDTH,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  usb_wren_l,
    input  logic                  usb_rden_l,
    input  logic                  usb_outen_l,
    input  logic                  usb_rst_l,
    input  logic [DATA_WIDTH-1:0] usb_data_in,
    output logic [DATA_WIDTH-1:0] usb_data_out,
    output logic                  usb_tx_full,
    output logic                  usb_rx_empty,
    output logic [DATA_WIDTH-1:0] host_rx_data,
    output logic                  host_rx_valid,
    input  logic                  host_rx_ready,
    input  logic [DATA_WIDTH-1:0] host_tx_data,
    input  logic                  host_tx_valid,
    output logic                  host_tx_ready,
    output logic [PERR_W-1:0]     proto_err
);

    localparam int              CNT_W    = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    ft601_strobe_t         strb_s;
    logic                  bus_flush_s;
    logic                  w_push_s;
    logic                  w_full_s;
    logic                  w_empty_s;
    logic [CNT_W-1:0]      w_count_s;
    logic                  r_pop_s;
    logic                  r_full_s;
    logic                  r_empty_s;
    logic [CNT_W-1:0]      r_count_s;
    logic [DATA_WIDTH-1:0] r_head_s;

    assign strb_s = '{wren_l: usb_wren_l, rden_l: usb_rden_l,
                      outen_l: usb_outen_l, rst_l: usb_rst_l};

    assign bus_flush_s = !strb_s.rst_l;
    assign w_push_s    = !strb_s.wren_l && strb_s.rst_l && !w_full_s;
    assign r_pop_s     = !strb_s.rden_l && !strb_s.outen_l && strb_s.rst_l && !r_empty_s;

    assign usb_tx_full   = (w_count_s == FULL_CNT);
    assign usb_rx_empty  = (r_count_s == ZERO_CNT);
    assign host_rx_valid = !w_empty_s;
    assign host_tx_ready = !r_full_s;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_w_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus_flush_s),
        .push      (w_push_s),
        .push_data (usb_data_in),
        .pop       (host_rx_ready),
        .head      (host_rx_data),
        .full      (w_full_s),
        .empty     (w_empty_s),
        .count     (w_count_s)
    );

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_r_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus_flush_s),
        .push      (host_tx_valid),
        .push_data (host_tx_data),
        .pop       (r_pop_s),
        .head      (r_head_s),
        .full      (r_full_s),
        .empty     (r_empty_s),
        .count     (r_count_s)
    );

    // Drive the bus only while output-enabled and a word is available.
    always_comb begin
        usb_data_out = {DATA_WIDTH{1'b0}};
        if (!strb_s.outen_l && !usb_rx_empty) begin
            usb_data_out = r_head_s;
        end else begin
            usb_data_out = {DATA_WIDTH{1'b0}};
        end
    end

`ifdef FT601_RESP_PROTO_CHECK_EN
    logic [PERR_W-1:0] proto_err_r;

    // Sticky error capture; only rst clears it, a bus reset keeps it.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_r <= {PERR_W{1'b0}};
        end else begin
            proto_err_r <= proto_err_r | proto_flags(strb_s, usb_tx_full, usb_rx_empty);
        end
    end

    assign proto_err = proto_err_r;
`else
    assign proto_err = {PERR_W{1'b0}};
`endif

endmodule

// File: tb/tb_ft601_fifo_responder.sv
// Scoreboard bench for ft601_fifo_responder; expected proto_err follows
// whether FT601_RESP_PROTO_CHECK_EN is defined for the build.
module tb_ft601_fifo_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
`ifdef FT601_RESP_PROTO_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          usb_wren_l, usb_rden_l, usb_outen_l, usb_rst_l;
    logic [DW-1:0] usb_data_in, usb_data_out;
    logic          usb_tx_full, usb_rx_empty;
    logic [DW-1:0] host_rx_data;
    logic          host_rx_valid, host_rx_ready;
    logic [DW-1:0] host_tx_data;
    logic          host_tx_valid, host_tx_ready;
    logic [3:0]    proto_err;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] w_q[$];
    logic [DW-1:0] r_q[$];
    logic [DW-1:0] exp_w;

    always #5 clk = ~clk;

    ft601_fifo_responder #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .usb_wren_l    (usb_wren_l),
        .usb_rden_l    (usb_rden_l),
        .usb_outen_l   (usb_outen_l),
        .usb_rst_l     (usb_rst_l),
        .usb_data_in   (usb_data_in),
        .usb_data_out  (usb_data_out),
        .usb_tx_full   (usb_tx_full),
        .usb_rx_empty  (usb_rx_empty),
        .host_rx_data  (host_rx_data),
        .host_rx_valid (host_rx_valid),
        .host_rx_ready (host_rx_ready),
        .host_tx_data  (host_tx_data),
        .host_tx_valid (host_tx_valid),
        .host_tx_ready (host_tx_ready),
        .proto_err     (proto_err)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        usb_wren_l    = 1'b1;
        usb_rden_l    = 1'b1;
        usb_outen_l   = 1'b1;
        usb_rst_l     = 1'b1;
        host_rx_ready = 1'b0;
        host_tx_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_q.delete();
        r_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        usb_outen_l = 1'b0;
        #1;
        checks++; if (usb_tx_full !== 1'b0) begin failures++; $display("FAIL reset_tx_full got=%b exp=0", usb_tx_full); end
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL reset_rx_empty got=%b exp=1", usb_rx_empty); end
        checks++; if (host_rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", host_rx_valid); end
        checks++; if (host_tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%b exp=1", host_tx_ready); end
        checks++; if (usb_data_out !== 32'h0) begin failures++; $display("FAIL reset_data_out got=%h exp=0", usb_data_out); end
        checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL reset_proto got=%b exp=0000", proto_err); end
        idle();
    endtask

    task automatic test_read_burst();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 32'hA0 + 32'(i);
            r_q.push_back(32'hA0 + 32'(i));
            tick();
        end
        host_tx_valid = 1'b0;
        usb_outen_l = 1'b0;
        usb_rden_l  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (usb_rx_empty !== 1'b0) begin failures++; $display("FAIL burst_not_empty i=%0d got=%b exp=0", i, usb_rx_empty); end
            exp_w = r_q.pop_front();
            checks++; if (usb_data_out !== exp_w) begin failures++; $display("FAIL burst_data i=%0d got=%h exp=%h", i, usb_data_out, exp_w); end
            tick();
        end
        #1;
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL burst_empty got=%b exp=1", usb_rx_empty); end
        checks++; if (usb_data_out !== 32'h0) begin failures++; $display("FAIL burst_out_zero got=%h exp=0", usb_data_out); end
        idle();
    endtask

    task automatic test_write_full();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            usb_wren_l  = 1'b0;
            usb_data_in = 32'h100 + 32'(i);
            if (i < 16) w_q.push_back(32'h100 + 32'(i));
            tick();
            if (i == 14) begin
                checks++; if (usb_tx_full !== 1'b0) begin failures++; $display("FAIL full_early got=%b exp=0", usb_tx_full); end
            end
            if (i == 15) begin
                checks++; if (usb_tx_full !== 1'b1) begin failures++; $display("FAIL full_at16 got=%b exp=1", usb_tx_full); end
            end
        end
        usb_wren_l = 1'b1;
        #1;
        checks++; if (proto_err !== (PC ? 4'b0001 : 4'b0000)) begin failures++; $display("FAIL full_proto got=%b exp=%b", proto_err, PC ? 4'b0001 : 4'b0000); end
        host_rx_ready = 1'b1;
        for (int k = 0; k < 20 && w_q.size() > 0; k++) begin
            #1;
            exp_w = w_q.pop_front();
            checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== exp_w) begin failures++; $display("FAIL full_drain k=%0d got=%h/%b exp=%h/1", k, host_rx_data, host_rx_valid, exp_w); end
            tick();
        end
        #1;
        checks++; if (host_rx_valid !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", host_rx_valid); end
        idle();
    endtask

    task automatic test_full_race();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            usb_wren_l  = 1'b0;
            usb_data_in = 32'h200 + 32'(i);
            w_q.push_back(32'h200 + 32'(i));
            tick();
        end
        usb_data_in   = 32'hDEAD;
        host_rx_ready = 1'b1;
        #1;
        exp_w = w_q.pop_front();
        checks++; if (host_rx_data !== exp_w) begin failures++; $display("FAIL race_head got=%h exp=%h", host_rx_data, exp_w); end
        tick();
        usb_wren_l    = 1'b1;
        host_rx_ready = 1'b0;
        #1;
        checks++; if (usb_tx_full !== 1'b0) begin failures++; $display("FAIL race_count15 got=%b exp=0", usb_tx_full); end
        usb_wren_l  = 1'b0;
        usb_data_in = 32'h300;
        w_q.push_back(32'h300);
        tick();
        usb_wren_l = 1'b1;
        #1;
        checks++; if (usb_tx_full !== 1'b1) begin failures++; $display("FAIL race_refill got=%b exp=1", usb_tx_full); end
        host_rx_ready = 1'b1;
        for (int k = 0; k < 20 && w_q.size() > 0; k++) begin
            #1;
            exp_w = w_q.pop_front();
            checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== exp_w) begin failures++; $display("FAIL race_drain k=%0d got=%h/%b exp=%h/1", k, host_rx_data, host_rx_valid, exp_w); end
            tick();
        end
        #1;
        checks++; if (host_rx_valid !== 1'b0) begin failures++; $display("FAIL race_drained got=%b exp=0", host_rx_valid); end
        idle();
    endtask

    task automatic test_usb_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            host_tx_valid = 1'b1;
            host_tx_data  = 32'hB0 + 32'(i);
            tick();
        end
        host_tx_valid = 1'b0;
        usb_rst_l   = 1'b0;
        usb_rden_l  = 1'b0;
        usb_outen_l = 1'b0;
        usb_wren_l  = 1'b0;
        usb_data_in = 32'h55;
        tick();
        idle();
        #1;
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL busrst_rx_empty got=%b exp=1", usb_rx_empty); end
        checks++; if (host_rx_valid !== 1'b0) begin failures++; $display("FAIL busrst_wr_ignored got=%b exp=0", host_rx_valid); end
        checks++; if (proto_err !== 4'b0000) begin failures++; $display("FAIL busrst_proto got=%b exp=0000", proto_err); end
        host_tx_valid = 1'b1;
        host_tx_data  = 32'hC5;
        r_q.push_back(32'hC5);
        tick();
        host_tx_valid = 1'b0;
        usb_outen_l   = 1'b0;
        #1;
        exp_w = r_q.pop_front();
        checks++; if (usb_data_out !== exp_w) begin failures++; $display("FAIL busrst_new_head got=%h exp=%h", usb_data_out, exp_w); end
        usb_rden_l = 1'b0;
        tick();
        idle();
        #1;
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL busrst_pop got=%b exp=1", usb_rx_empty); end
    endtask

    task automatic test_proto();
        do_reset();
        usb_rden_l  = 1'b0;
        usb_outen_l = 1'b1;
        tick();
        usb_rden_l  = 1'b1;
        usb_wren_l  = 1'b0;
        usb_outen_l = 1'b0;
        usb_data_in = 32'h77;
        w_q.push_back(32'h77);
        #1;
        checks++; if (usb_data_out !== 32'h0) begin failures++; $display("FAIL proto_out_zero got=%h exp=0", usb_data_out); end
        tick();
        idle();
        #1;
        checks++; if (proto_err !== (PC ? 4'b1100 : 4'b0000)) begin failures++; $display("FAIL proto_bits got=%b exp=%b", proto_err, PC ? 4'b1100 : 4'b0000); end
        exp_w = w_q.pop_front();
        checks++; if (host_rx_valid !== 1'b1 || host_rx_data !== exp_w) begin failures++; $display("FAIL proto_wdata got=%h/%b exp=%h/1", host_rx_data, host_rx_valid, exp_w); end
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL proto_rx_empty got=%b exp=1", usb_rx_empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        host_tx_valid = 1'b1;
        host_tx_data  = 32'hD0;
        r_q.push_back(32'hD0);
        tick();
        usb_rden_l  = 1'b0;
        usb_outen_l = 1'b0;
        for (int i = 1; i < 7; i++) begin
            host_tx_data = 32'hD0 + 32'(i);
            r_q.push_back(32'hD0 + 32'(i));
            #1;
            checks++; if (usb_data_out !== r_q[0]) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, usb_data_out, r_q[0]); end
            checks++; if (host_tx_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, host_tx_ready); end
            tick();
            void'(r_q.pop_front());
        end
        host_tx_valid = 1'b0;
        #1;
        exp_w = r_q.pop_front();
        checks++; if (usb_data_out !== exp_w) begin failures++; $display("FAIL b2b_last got=%h exp=%h", usb_data_out, exp_w); end
        tick();
        idle();
        #1;
        checks++; if (usb_rx_empty !== 1'b1) begin failures++; $display("FAIL b2b_empty got=%b exp=1", usb_rx_empty); end
    endtask

    initial begin
        usb_data_in  = 32'h0;
        host_tx_data = 32'h0;
        idle();
        rst = 1'b1;
        repeat (2) tick();
        test_reset();
        test_read_burst();
        test_write_full();
        test_full_race();
        test_usb_reset();
        test_proto();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ft601_fifo_responder.md
FT601_FIFO_RESPONDER -- requirements
Module: ft601_fifo_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the FIFO-bus word width.
REQ-002 SHALL have parameter DEPTH, default 16 (power of two, at least 4), meaning the entries per internal FIFO.
REQ-003 SHALL have one clock and a synchronous, active-high reset; no other clocks.
REQ-004 clk  input  1  sole clock, all state on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 usb_wren_l  input  1  controller write strobe, active low.
REQ-007 usb_rden_l  input  1  controller read strobe, active low.
REQ-008 usb_outen_l  input  1  controller output-enable, active low.
REQ-009 usb_rst_l  input  1  controller-issued bus reset, active low.
REQ-010 usb_data_in  input  DATA_WIDTH  word written by controller.
REQ-011 usb_data_out  output  DATA_WIDTH  word presented to controller.
REQ-012 usb_tx_full  output  1  write FIFO (W-FIFO) cannot accept a word.
REQ-013 usb_rx_empty  output  1  read FIFO (R-FIFO) holds no word.
REQ-014 host_rx_data / host_rx_valid / host_rx_ready  out/out/in  DATA_WIDTH/1/1  drain side of W-FIFO.
REQ-015 host_tx_data / host_tx_valid / host_tx_ready  in/in/out  DATA_WIDTH/1/1  fill side of R-FIFO.
REQ-016 proto_err  output  4  sticky protocol-error flags, see REQ-030.

Function
REQ-017 usb_tx_full SHALL equal (W-FIFO count == DEPTH), combinationally from registered count.
REQ-018 usb_rx_empty SHALL equal (R-FIFO count == 0), combinationally from registered count.
REQ-019 A word SHALL be pushed into W-FIFO on an edge where usb_wren_l=0, usb_tx_full=0 and usb_rst_l=1.
REQ-020 A write with usb_tx_full=1 SHALL be dropped, with W-FIFO unchanged.
REQ-021 usb_data_out SHALL show the R-FIFO head combinationally whenever usb_outen_l=0 and usb_rx_empty=0; otherwise it SHALL be all zeros.
REQ-022 R-FIFO SHALL pop on an edge where usb_rden_l=0, usb_outen_l=0, usb_rx_empty=0 and usb_rst_l=1; the next head SHALL appear the following cycle (one word per cycle at full rate).
REQ-023 A read with usb_rx_empty=1 SHALL leave the R-FIFO unchanged.
REQ-024 Host sides SHALL use a valid/ready handshake: transfer on valid&&ready; host_tx_ready=!full(R-FIFO); host_rx_valid=!empty(W-FIFO); host_rx_data=W-FIFO head.
REQ-025 Simultaneous push and pop on the same FIFO SHALL be allowed at any count, including full (pop frees the slot the same cycle only for the host side) and empty (no fall-through; the pushed word is visible the next cycle).
REQ-026 Pointers SHALL wrap modulo DEPTH; counts SHALL be log2(DEPTH)+1 bits wide and never exceed DEPTH.
REQ-027 usb_rst_l=0 on an edge SHALL flush both FIFOs (counts and pointers to 0) and ignore every strobe that cycle; proto_err SHALL be kept.
REQ-028 Strobes SHALL be sampled only; the responder SHALL impose no wait states beyond full/empty.

Reset
REQ-029 With rst=1 on an edge: both FIFOs empty, pointers 0, proto_err=0. As a result usb_tx_full=0, usb_rx_empty=1, host_rx_valid=0, host_tx_ready=1, usb_data_out=0. rst SHALL take priority over usb_rst_l and all strobes.

Configuration
REQ-030 With macro FT601_RESP_PROTO_CHECK_EN defined, proto_err SHALL set bits as follows and hold them until rst:
- [0] write while full
- [1] read while empty
- [2] usb_rden_l=0 with usb_outen_l=1
- [3] usb_wren_l=0 and usb_outen_l=0 in the same cycle (bus contention)
REQ-031 Without the macro, proto_err SHALL be constant 0 and no checker logic SHALL be synthesized; data behaviour SHALL be identical in both builds.

Structure
REQ-032 A shared package ft601_pkg SHALL hold the DATA_WIDTH default, the proto_err bit-index constants, and a typedef for the FT601 control-strobe bundle.
REQ-033 A sub-module sync_fifo (parameters DATA_WIDTH, DEPTH; push/pop/full/empty/count) SHALL be instantiated twice, once for W-FIFO and once for R-FIFO.

Verification
REQ-034 After reset, inject 0xA0..0xA2 on host_tx; hold outen_l=0 and rden_l=0 for 3 cycles -> usb_data_out reads A0, A1, A2 on consecutive cycles, then usb_rx_empty=1.
REQ-035 DEPTH=16, host_rx_ready=0, 17 writes 0x100..0x110 -> usb_tx_full=1 after the 16th; 0x110 is dropped; the drain yields 0x100..0x10F in order; proto_err[0]=1 when the macro is defined.
REQ-036 W-FIFO full, a write and host_rx_ready=1 in the same cycle -> one word is drained, the write is dropped, count=15 the next cycle.
REQ-037 4 words in R-FIFO, usb_rst_l=0 for 1 cycle together with rden_l=0 -> usb_rx_empty=1 the next cycle, no pop is counted, proto_err is unchanged.
REQ-038 rden_l=0 with outen_l=1, then wren_l=0 with outen_l=0 -> proto_err=4'b1100 with the macro defined, 4'b0000 without; FIFO contents are identical in both builds.
